pipe_control_unit: RTL and testbench
====================================

# pipe_control_unit

Pipelined successor to the single-cycle MIPS control decoder. It decodes the IF/ID instruction into the full control bundle and carries each field group through the ID/EX, MEM and MEM/WB control registers. It handles stall, flush and sticky halt, and supports a configurable number of memory stages. It sits beside the datapath pipeline registers and is the only source of per-stage control signals.

## Interface
Parameters:
- MEM_STAGES, 1, number of MEM control registers between EX and WB (legal range 1..3).
- ILLEGAL_HALT, 1, unknown opcode/funct decodes as HALT when 1, as a bubble when 0.

Ports (one clock `CLK`; reset `nRST` is asynchronous and active-low):
- CLK  in  1  clock, rising edge.
- nRST  in  1  asynchronous, active-low reset.
- instr  in  32  IF/ID instruction (word_t).
- instr_v  in  1  instr holds a real instruction; 0 means insert a bubble.
- stall  in  1  freeze every control register.
- flush  in  1  load a bubble into ID/EX.
- ex_ALUop  out  4  aluop_t for the EX stage.
- ex_alusrc, ex_ext, ex_lui, ex_shift, ex_regdst  out  1 each  EX controls.
- ex_branch, ex_bne, ex_jumpi, ex_jumpreg  out  1 each  control-flow resolution in EX.
- mem_memwr, mem_memread  out  1 each  from the last MEM register.
- wb_regwr, wb_memtoreg, wb_jumpal  out  1 each  from the WB register.
- halt  out  1  sticky; set when a HALT entry occupies the WB register.
- busy  out  1  OR of the valid bits of all stage registers.

## Operation
- **Decode rules (MIPS, cpu_types_pkg encodings):**
  - regdst = RTYPE.
  - alusrc = ADDIU/ANDI/LUI/LW/ORI/SLTI/SLTIU/SW/LL/SC/XORI.
  - ext = 0 for ANDI/LUI/ORI/XORI, else 1.
  - shift = RTYPE and (SLL or SRL).
  - branch = BEQ or BNE; bne = BNE.
  - jumpi = J or JAL; jumpreg = RTYPE and JR; jumpal = JAL.
  - memread = LW; memwr = SW; memtoreg = LW.
  - regwr = 0 for JR/BEQ/BNE/SW/J/HALT, else 1.
- **ALUop:**
  - RTYPE: from funct. SLL/SRL; ADD/ADDU map to ADD; SUB/SUBU map to SUB; AND/OR/XOR/NOR/SLT/SLTU map directly.
  - Immediate forms: ADDIU/LW/SW/LL/SC use ADD; ANDI uses AND; ORI/LUI use OR; BEQ/BNE use SUB; SLTI uses SLT; SLTIU uses SLTU; XORI uses XOR.
- **Illegal instructions:** an unknown opcode, or an unknown RTYPE funct, becomes HALT (ILLEGAL_HALT=1) or a bubble (ILLEGAL_HALT=0).
- **Stage registers:** ID/EX, then MEM[0..MEM_STAGES-1], then WB. Each holds a valid bit, a halt bit and the fields still needed downstream.
- **Bubble:** valid=0, every field 0, ALUop=0.
- **Advance:** when stall=0, every register loads from its predecessor on the rising edge. ID/EX loads the decoded instr, or a bubble if instr_v=0, flush=1 or halt_pending=1.
- **Stall priority:** stall=1 holds every register, including through flush. Flush is level-sensitive and the requester must hold it until stall drops.
- **halt_pending:** set when a HALT enters ID/EX. From then on every ID/EX load is a bubble, so no instruction younger than HALT ever reaches WB. It is cleared only by reset.
- **halt output:** set on the edge at which a HALT entry loads into WB. It stays 1 until reset. After HALT drains out of WB, the pipeline holds only bubbles and busy falls to 0.
- **Reset:** nRST=0 asynchronously clears all registers, halt_pending and halt. Every output is 0 during and after reset until the first load.

## Timing
- instr captured at edge t drives ex_* during cycle t+1, mem_* during cycle t+MEM_STAGES+1, and wb_* during cycle t+MEM_STAGES+2.
- Each stall cycle adds one cycle of latency to every in-flight entry.
- All outputs are registered; there is no combinational path from instr, stall or flush to any output.
- halt rises in the same cycle the HALT entry's wb_* fields are presented.
- Reset asserted mid-operation clears everything in that cycle. There is no partial drain.

## Test plan
- Reset, then ADDIU 0x24210004 with instr_v=1 at edge 0 and MEM_STAGES=1:
  - cycle 1: ex_alusrc=1, ex_ext=1, ex_ALUop=ALU_ADD.
  - cycle 3: wb_regwr=1, wb_memtoreg=0.
- MEM_STAGES=2, LW 0x8C220000 at edge 0:
  - cycle 3: mem_memread=1.
  - cycle 4: wb_memtoreg=1, wb_regwr=1.
  - SW 0xAC220000 on the same path: mem_memwr=1, wb_regwr=0.
- LW then ADDU 0x00221821, with stall held for 3 cycles once LW is in MEM:
  - all outputs stay frozen for exactly 3 cycles.
  - on release, order and values resume unchanged.
- BEQ 0x10220002 in EX (ex_branch=1, ex_ALUop=ALU_SUB), then flush=1 for one cycle:
  - next cycle shows all ex_* equal to 0.
  - flush=1 together with stall=1: registers hold; the bubble enters only after stall drops.
- HALT 0xFFFFFFFF followed by ADDU:
  - halt=1 at cycle MEM_STAGES+2 and stays 1.
  - ADDU never produces wb_regwr=1; busy returns to 0.
  - pulse nRST low asynchronously: halt and busy drop immediately.
- Opcode 0x7C000000:
  - ILLEGAL_HALT=0: bubble, with no control asserted at any stage.
  - ILLEGAL_HALT=1: halt asserts at cycle MEM_STAGES+2.

Source files
------------

// File: rtl/pipe_control_unit.sv
// Pipelined MIPS control: decodes the IF/ID instruction and carries each control group
// through ID/EX, MEM_STAGES memory registers and MEM/WB, with stall, flush and sticky halt.
module pipe_control_unit #(
  parameter int unsigned MEM_STAGES   = 1,
  parameter bit          ILLEGAL_HALT = 1'b1
) (
  input  logic        CLK,
  input  logic        nRST,
  input  logic [31:0] instr,
  input  logic        instr_v,
  input  logic        stall,
  input  logic        flush,
  output logic [3:0]  ex_ALUop,
  output logic        ex_alusrc,
  output logic        ex_ext,
  output logic        ex_lui,
  output logic        ex_shift,
  output logic        ex_regdst,
  output logic        ex_branch,
  output logic        ex_bne,
  output logic        ex_jumpi,
  output logic        ex_jumpreg,
  output logic        mem_memwr,
  output logic        mem_memread,
  output logic        wb_regwr,
  output logic        wb_memtoreg,
  output logic        wb_jumpal,
  output logic        halt,
  output logic        busy
);

  localparam logic [5:0] OpRtype = 6'h00, OpJ     = 6'h02, OpJal  = 6'h03, OpBeq  = 6'h04;
  localparam logic [5:0] OpBne   = 6'h05, OpAddiu = 6'h09, OpSlti = 6'h0a, OpSltiu = 6'h0b;
  localparam logic [5:0] OpAndi  = 6'h0c, OpOri   = 6'h0d, OpXori = 6'h0e, OpLui  = 6'h0f;
  localparam logic [5:0] OpLw    = 6'h23, OpSw    = 6'h2b, OpLl   = 6'h30, OpSc   = 6'h38;
  localparam logic [5:0] OpHalt  = 6'h3f;

  localparam logic [5:0] FnSll = 6'h00, FnSrl = 6'h02, FnJr  = 6'h08, FnAdd  = 6'h20;
  localparam logic [5:0] FnAddu = 6'h21, FnSub = 6'h22, FnSubu = 6'h23, FnAnd = 6'h24;
  localparam logic [5:0] FnOr  = 6'h25, FnXor = 6'h26, FnNor = 6'h27, FnSlt  = 6'h2a;
  localparam logic [5:0] FnSltu = 6'h2b;

  localparam logic [3:0] AluSll = 4'd0, AluSrl = 4'd1, AluAdd = 4'd2, AluSub = 4'd3;
  localparam logic [3:0] AluAnd = 4'd4, AluOr  = 4'd5, AluXor = 4'd6, AluNor = 4'd7;
  localparam logic [3:0] AluSlt = 4'd8, AluSltu = 4'd9;

  typedef struct packed {
    logic       valid;
    logic       halt;
    logic [3:0] aluop;
    logic       alusrc;
    logic       ext;
    logic       lui;
    logic       shift;
    logic       regdst;
    logic       branch;
    logic       bne;
    logic       jumpi;
    logic       jumpreg;
    logic       memwr;
    logic       memread;
    logic       regwr;
    logic       memtoreg;
    logic       jumpal;
  } idex_t;

  typedef struct packed {
    logic valid;
    logic halt;
    logic memwr;
    logic memread;
    logic regwr;
    logic memtoreg;
    logic jumpal;
  } mem_t;

  typedef struct packed {
    logic valid;
    logic halt;
    logic regwr;
    logic memtoreg;
    logic jumpal;
  } wb_t;

  logic [5:0] op, fn;
  logic       legal;
  idex_t      dec, idex_d, idex_q;
  mem_t       mem_in;
  mem_t       mem_src [MEM_STAGES];
  mem_t       mem_q   [MEM_STAGES];
  wb_t        wb_d, wb_q;
  logic       halt_pending_q, halt_q;
  logic [MEM_STAGES-1:0] mem_valid;
  logic       unused_instr;

  assign op           = instr[31:26];
  assign fn           = instr[5:0];
  assign unused_instr = ^instr[25:6];

  always_comb begin
    dec        = '0;
    dec.valid  = 1'b1;
    dec.ext    = 1'b1;
    dec.regwr  = 1'b1;
    legal      = 1'b1;
    case (op)
      OpRtype: begin
        dec.regdst = 1'b1;
        case (fn)
          FnSll:          begin dec.aluop = AluSll; dec.shift = 1'b1; end
          FnSrl:          begin dec.aluop = AluSrl; dec.shift = 1'b1; end
          FnJr:           begin dec.jumpreg = 1'b1; dec.regwr = 1'b0; end
          FnAdd, FnAddu:  dec.aluop = AluAdd;
          FnSub, FnSubu:  dec.aluop = AluSub;
          FnAnd:          dec.aluop = AluAnd;
          FnOr:           dec.aluop = AluOr;
          FnXor:          dec.aluop = AluXor;
          FnNor:          dec.aluop = AluNor;
          FnSlt:          dec.aluop = AluSlt;
          FnSltu:         dec.aluop = AluSltu;
          default:        legal = 1'b0;
        endcase
      end
      OpJ:     begin dec.jumpi = 1'b1; dec.regwr = 1'b0; end
      OpJal:   begin dec.jumpi = 1'b1; dec.jumpal = 1'b1; end
      OpBeq:   begin dec.branch = 1'b1; dec.aluop = AluSub; dec.regwr = 1'b0; end
      OpBne:   begin
        dec.branch = 1'b1;
        dec.bne    = 1'b1;
        dec.aluop  = AluSub;
        dec.regwr  = 1'b0;
      end
      OpAddiu, OpLl, OpSc: begin dec.alusrc = 1'b1; dec.aluop = AluAdd; end
      OpSlti:  begin dec.alusrc = 1'b1; dec.aluop = AluSlt; end
      OpSltiu: begin dec.alusrc = 1'b1; dec.aluop = AluSltu; end
      OpAndi:  begin dec.alusrc = 1'b1; dec.ext = 1'b0; dec.aluop = AluAnd; end
      OpOri:   begin dec.alusrc = 1'b1; dec.ext = 1'b0; dec.aluop = AluOr; end
      OpXori:  begin dec.alusrc = 1'b1; dec.ext = 1'b0; dec.aluop = AluXor; end
      OpLui:   begin
        dec.alusrc = 1'b1;
        dec.ext    = 1'b0;
        dec.lui    = 1'b1;
        dec.aluop  = AluOr;
      end
      OpLw:    begin
        dec.alusrc   = 1'b1;
        dec.aluop    = AluAdd;
        dec.memread  = 1'b1;
        dec.memtoreg = 1'b1;
      end
      OpSw:    begin
        dec.alusrc = 1'b1;
        dec.aluop  = AluAdd;
        dec.memwr  = 1'b1;
        dec.regwr  = 1'b0;
      end
      OpHalt:  begin dec.halt = 1'b1; dec.regwr = 1'b0; end
      default: legal = 1'b0;
    endcase
    // An illegal word becomes either a plain HALT entry or nothing at all.
    if (!legal) begin
      dec = '0;
      if (ILLEGAL_HALT) begin
        dec.valid = 1'b1;
        dec.halt  = 1'b1;
        dec.ext   = 1'b1;
      end
    end
  end

  always_comb begin
    idex_d = (!instr_v || flush || halt_pending_q) ? '0 : dec;

    mem_in.valid    = idex_q.valid;
    mem_in.halt     = idex_q.halt;
    mem_in.memwr    = idex_q.memwr;
    mem_in.memread  = idex_q.memread;
    mem_in.regwr    = idex_q.regwr;
    mem_in.memtoreg = idex_q.memtoreg;
    mem_in.jumpal   = idex_q.jumpal;

    wb_d.valid    = mem_q[MEM_STAGES-1].valid;
    wb_d.halt     = mem_q[MEM_STAGES-1].halt;
    wb_d.regwr    = mem_q[MEM_STAGES-1].regwr;
    wb_d.memtoreg = mem_q[MEM_STAGES-1].memtoreg;
    wb_d.jumpal   = mem_q[MEM_STAGES-1].jumpal;
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      idex_q         <= '0;
      wb_q           <= '0;
      halt_pending_q <= 1'b0;
      halt_q         <= 1'b0;
    end else if (!stall) begin
      idex_q         <= idex_d;
      wb_q           <= wb_d;
      halt_pending_q <= halt_pending_q | idex_d.halt;
      halt_q         <= halt_q | wb_d.halt;
    end
  end

  for (genvar g = 0; g < MEM_STAGES; g++) begin : g_mem
    if (g == 0) begin : g_first
      assign mem_src[g] = mem_in;
    end else begin : g_next
      assign mem_src[g] = mem_q[g-1];
    end

    always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
        mem_q[g] <= '0;
      end else if (!stall) begin
        mem_q[g] <= mem_src[g];
      end
    end

    assign mem_valid[g] = mem_q[g].valid;
  end

  assign ex_ALUop    = idex_q.aluop;
  assign ex_alusrc   = idex_q.alusrc;
  assign ex_ext      = idex_q.ext;
  assign ex_lui      = idex_q.lui;
  assign ex_shift    = idex_q.shift;
  assign ex_regdst   = idex_q.regdst;
  assign ex_branch   = idex_q.branch;
  assign ex_bne      = idex_q.bne;
  assign ex_jumpi    = idex_q.jumpi;
  assign ex_jumpreg  = idex_q.jumpreg;
  assign mem_memwr   = mem_q[MEM_STAGES-1].memwr;
  assign mem_memread = mem_q[MEM_STAGES-1].memread;
  assign wb_regwr    = wb_q.regwr;
  assign wb_memtoreg = wb_q.memtoreg;
  assign wb_jumpal   = wb_q.jumpal;
  assign halt        = halt_q;
  assign busy        = idex_q.valid | (|mem_valid) | wb_q.valid;

endmodule

// File: tb/tb_pipe_control_unit.sv
// Bench for pipe_control_unit: three instances (MEM_STAGES 1/2/3, ILLEGAL_HALT 1/0/1) share
// one stimulus stream and are checked every cycle against a history-indexed reference model.
module tb_pipe_control_unit;

  logic        CLK = 1'b0;
  logic        nRST = 1'b0;
  logic [31:0] instr = '0;
  logic        instr_v = 1'b0, stall = 1'b0, flush = 1'b0;

  always #5 CLK = ~CLK;

  localparam logic [31:0] WAddiu = 32'h24210004, WLw = 32'h8C220000, WSw = 32'hAC220000;
  localparam logic [31:0] WAddu = 32'h00221821, WBeq = 32'h10220002, WHalt = 32'hFFFFFFFF;
  localparam logic [31:0] WIll = 32'h7C000000;

  typedef struct packed {
    logic v, h;
    logic [3:0] aluop;
    logic alusrc, ext, lui, shift, regdst, branch, bne, jumpi, jumpreg;
    logic memwr, memread, regwr, memtoreg, jumpal;
  } ent_t;

  // obs bits: 19:16 ALUop, 15 alusrc, 14 ext, 13 lui, 12 shift, 11 regdst, 10 branch, 9 bne,
  // 8 jumpi, 7 jumpreg, 6 memwr, 5 memread, 4 wb_regwr, 3 wb_memtoreg, 2 wb_jumpal, 1 halt, 0 busy
  logic [19:0] obs [3];

  for (genvar g = 0; g < 3; g++) begin : g_dut
    logic [3:0] alu;
    logic alusrc, ext, lui, shift, regdst, branch, bne, jumpi, jumpreg;
    logic memwr, memread, regwr, memtoreg, jumpal, hlt, bsy;

    pipe_control_unit #(
      .MEM_STAGES  (g + 1),
      .ILLEGAL_HALT(g != 1)
    ) u_dut (
      .CLK        (CLK),
      .nRST       (nRST),
      .instr      (instr),
      .instr_v    (instr_v),
      .stall      (stall),
      .flush      (flush),
      .ex_ALUop   (alu),
      .ex_alusrc  (alusrc),
      .ex_ext     (ext),
      .ex_lui     (lui),
      .ex_shift   (shift),
      .ex_regdst  (regdst),
      .ex_branch  (branch),
      .ex_bne     (bne),
      .ex_jumpi   (jumpi),
      .ex_jumpreg (jumpreg),
      .mem_memwr  (memwr),
      .mem_memread(memread),
      .wb_regwr   (regwr),
      .wb_memtoreg(memtoreg),
      .wb_jumpal  (jumpal),
      .halt       (hlt),
      .busy       (bsy)
    );

    assign obs[g] = {alu, alusrc, ext, lui, shift, regdst, branch, bne, jumpi, jumpreg,
                     memwr, memread, regwr, memtoreg, jumpal, hlt, bsy};
  end

  // Model: hist[d][k] is the entry loaded into ID/EX on the k-th advancing edge since reset.
  ent_t hist [3][256];
  int   n = 0;
  int   total = 0, bad = 0;
  bit   chk_en = 1'b0;
  logic [19:0] snap0, snap2;

  function automatic ent_t dec(input logic [31:0] w, input bit ih);
    logic [5:0] op, fn;
    ent_t e;
    bit ok;
    op = w[31:26];
    fn = w[5:0];
    e  = '0;
    ok = (op inside {0, 2, 3, 4, 5, 9, 10, 11, 12, 13, 14, 15, 35, 43, 48, 56, 63}) &&
         (op != 0 || fn inside {0, 2, 8, [32:39], 42, 43});
    if (!ok) begin
      if (ih) begin e.v = 1'b1; e.h = 1'b1; e.ext = 1'b1; end
      return e;
    end
    e.v        = 1'b1;
    e.h        = (op == 63);
    e.regdst   = (op == 0);
    e.alusrc   = op inside {9, 10, 11, 12, 13, 14, 15, 35, 43, 48, 56};
    e.ext      = !(op inside {12, 13, 14, 15});
    e.lui      = (op == 15);
    e.shift    = (op == 0) && (fn inside {0, 2});
    e.branch   = op inside {4, 5};
    e.bne      = (op == 5);
    e.jumpi    = op inside {2, 3};
    e.jumpreg  = (op == 0) && (fn == 8);
    e.jumpal   = (op == 3);
    e.memread  = (op == 35);
    e.memtoreg = (op == 35);
    e.memwr    = (op == 43);
    e.regwr    = !(((op == 0) && (fn == 8)) || (op inside {2, 4, 5, 43, 63}));
    if (op == 0) begin
      case (fn)
        2: e.aluop = 1;       32, 33: e.aluop = 2;  34, 35: e.aluop = 3;
        36: e.aluop = 4;      37: e.aluop = 5;      38: e.aluop = 6;
        39: e.aluop = 7;      42: e.aluop = 8;      43: e.aluop = 9;
        default: e.aluop = 0;
      endcase
    end else begin
      case (op)
        9, 35, 43, 48, 56: e.aluop = 2;
        4, 5:   e.aluop = 3;
        12:     e.aluop = 4;
        13, 15: e.aluop = 5;
        14:     e.aluop = 6;
        10:     e.aluop = 8;
        11:     e.aluop = 9;
        default: e.aluop = 0;
      endcase
    end
    return e;
  endfunction

  function automatic ent_t at(input int d, input int i);
    if (i < 0 || i >= 256) return '0;
    return hist[d][i];
  endfunction

  function automatic bit pend(input int d);
    bit p = 1'b0;
    for (int i = 0; i < n; i++) p |= hist[d][i].h;
    return p;
  endfunction

  function automatic logic [19:0] exp_obs(input int d);
    int m;
    ent_t ex, mm, wb;
    logic bz, hl;
    m  = d + 1;
    ex = at(d, n - 1);
    mm = at(d, n - 1 - m);
    wb = at(d, n - 2 - m);
    bz = 1'b0;
    for (int k = 0; k <= m + 1; k++) bz |= at(d, n - 1 - k).v;
    hl = 1'b0;
    for (int i = 0; i <= n - 2 - m; i++) hl |= hist[d][i].h;
    return {ex.aluop, ex.alusrc, ex.ext, ex.lui, ex.shift, ex.regdst, ex.branch, ex.bne,
            ex.jumpi, ex.jumpreg, mm.memwr, mm.memread, wb.regwr, wb.memtoreg, wb.jumpal,
            hl, bz};
  endfunction

  task automatic model_step();
    ent_t nx [3];
    for (int d = 0; d < 3; d++)
      nx[d] = (instr_v && !flush && !pend(d)) ? dec(instr, d != 1) : '0;
    if (n < 256) for (int d = 0; d < 3; d++) hist[d][n] = nx[d];
    n++;
  endtask

  always @(negedge CLK) begin
    logic [19:0] e;
    if (chk_en) begin
      for (int d = 0; d < 3; d++) begin
        e = exp_obs(d);
        total++;
        if (obs[d] !== e) begin
          bad++;
          $display("FAIL model_dut%0d n=%0d: got %h want %h", d, n, obs[d], e);
        end
      end
    end
  end

  task automatic lit(input string nm, input logic [31:0] act, input logic [31:0] want);
    total++;
    if (act !== want) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, want);
    end
  endtask

  task automatic step(input logic [31:0] w, input bit v, input bit s, input bit f);
    instr   = w;
    instr_v = v;
    stall   = s;
    flush   = f;
    @(posedge CLK);
    if (nRST && !stall) model_step();
    @(negedge CLK);
  endtask

  task automatic do_reset();
    #2;
    nRST = 1'b0;
    n = 0;
    instr = '0; instr_v = 1'b0; stall = 1'b0; flush = 1'b0;
    @(negedge CLK);
    @(negedge CLK);
    nRST = 1'b1;
  endtask

  function automatic logic [31:0] rand_instr();
    logic [5:0] ops [15] = '{6'h02, 6'h03, 6'h04, 6'h05, 6'h09, 6'h0a, 6'h0b, 6'h0c, 6'h0d,
                             6'h0e, 6'h0f, 6'h23, 6'h2b, 6'h30, 6'h38};
    logic [5:0] fns [13] = '{6'h00, 6'h02, 6'h08, 6'h20, 6'h21, 6'h22, 6'h23, 6'h24, 6'h25,
                             6'h26, 6'h27, 6'h2a, 6'h2b};
    logic [31:0] w;
    int k;
    w = $urandom;
    k = $urandom_range(0, 99);
    if (k < 2)       w[31:26] = 6'h3f;
    else if (k < 6)  w = w;
    else if (k < 30) begin
      w[31:26] = 6'h00;
      if ($urandom_range(0, 9) != 0) w[5:0] = fns[$urandom_range(0, 12)];
    end else         w[31:26] = ops[$urandom_range(0, 14)];
    return w;
  endfunction

  initial begin
    do_reset();
    chk_en = 1'b1;
    lit("reset_dut0", {12'h0, obs[0]}, 32'h0);
    lit("reset_dut2", {12'h0, obs[2]}, 32'h0);

    // ADDIU through the MEM_STAGES=1 instance
    step(WAddiu, 1, 0, 0);
    lit("addiu_ex_alusrc", {31'h0, obs[0][15]}, 32'd1);
    lit("addiu_ex_ext", {31'h0, obs[0][14]}, 32'd1);
    lit("addiu_ex_aluop", {28'h0, obs[0][19:16]}, 32'd2);
    step('0, 0, 0, 0);
    step('0, 0, 0, 0);
    lit("addiu_wb_regwr_memtoreg", {30'h0, obs[0][4:3]}, 32'b10);

    // LW then SW through the MEM_STAGES=2 instance
    do_reset();
    step(WLw, 1, 0, 0);
    step(WSw, 1, 0, 0);
    step('0, 0, 0, 0);
    lit("lw_mem_memread_c3", {31'h0, obs[1][5]}, 32'd1);
    step('0, 0, 0, 0);
    lit("lw_wb_c4", {30'h0, obs[1][4:3]}, 32'b11);
    lit("sw_mem_memwr_c4", {31'h0, obs[1][6]}, 32'd1);
    step('0, 0, 0, 0);
    lit("sw_wb_regwr_c5", {31'h0, obs[1][4]}, 32'd0);

    // Stall freeze with LW in MEM, ADDU in EX
    do_reset();
    step(WLw, 1, 0, 0);
    step(WAddu, 1, 0, 0);
    lit("stall_pre_memread", {31'h0, obs[0][5]}, 32'd1);
    snap0 = obs[0];
    snap2 = obs[2];
    repeat (3) begin
      step(WBeq, 1, 1, 0);
      lit("stall_hold_dut0", {12'h0, obs[0]}, {12'h0, snap0});
      lit("stall_hold_dut2", {12'h0, obs[2]}, {12'h0, snap2});
    end
    step('0, 0, 0, 0);
    lit("stall_release_lw_wb", {30'h0, obs[0][4:3]}, 32'b11);
    step('0, 0, 0, 0);
    lit("stall_release_addu_wb", {30'h0, obs[0][4:3]}, 32'b10);

    // Flush, and flush held under stall
    do_reset();
    step(WBeq, 1, 0, 0);
    lit("beq_ex_branch", {31'h0, obs[0][10]}, 32'd1);
    lit("beq_ex_aluop", {28'h0, obs[0][19:16]}, 32'd3);
    step(WAddu, 1, 1, 1);
    lit("flush_under_stall_holds", {31'h0, obs[0][10]}, 32'd1);
    step(WAddu, 1, 0, 1);
    lit("flush_ex_zero", {19'h0, obs[0][19:7]}, 32'h0);

    // HALT followed by ADDU: sticky halt, drain to idle
    do_reset();
    step(WHalt, 1, 0, 0);
    step(WAddu, 1, 0, 0);
    lit("halt_low_c2", {31'h0, obs[0][1]}, 32'd0);
    step(WAddu, 1, 0, 0);
    lit("halt_c3_dut0", {31'h0, obs[0][1]}, 32'd1);
    repeat (4) step(WAddu, 1, 0, 0);
    lit("halt_drained_dut0", {30'h0, obs[0][1:0]}, 32'b10);
    lit("halt_drained_dut2", {30'h0, obs[2][1:0]}, 32'b10);

    // Asynchronous reset while halted and busy
    do_reset();
    step(WHalt, 1, 0, 0);
    step('0, 0, 0, 0);
    step('0, 0, 0, 0);
    lit("pre_async_dut0", {30'h0, obs[0][1:0]}, 32'b11);
    #2;
    nRST = 1'b0;
    n = 0;
    #1;
    lit("async_rst_dut0", {30'h0, obs[0][1:0]}, 32'b00);
    lit("async_rst_dut2_busy", {31'h0, obs[2][0]}, 32'd0);
    @(negedge CLK);
    nRST = 1'b1;

    // Illegal opcode: bubble on ILLEGAL_HALT=0, HALT otherwise
    step(WIll, 1, 0, 0);
    lit("illegal_bubble_c1", {12'h0, obs[1]}, 32'h0);
    lit("illegal_halt_busy_c1", {31'h0, obs[0][0]}, 32'd1);
    step('0, 0, 0, 0);
    step('0, 0, 0, 0);
    lit("illegal_halt_c3", {31'h0, obs[0][1]}, 32'd1);
    lit("illegal_bubble_c3", {12'h0, obs[1]}, 32'h0);

    // Randomized traffic
    do_reset();
    for (int it = 0; it < 2500; it++) begin
      if (n > 200 || $urandom_range(0, 149) == 0) do_reset();
      step(rand_instr(), $urandom_range(0, 9) != 0, $urandom_range(0, 4) == 0,
           $urandom_range(0, 9) == 0);
    end

    chk_en = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
